param_memory: RTL and testbench

- Parametrised single-port synchronous RAM for the simple_circuit datapath. It is the next generation of the fixed 256x8 store.
- Adds configurable width and depth, a registered read with a valid/ready handshake, per-bit write masking, a hardware clear engine after reset, and out-of-range detection.
- Sits between the control FSM and any unit needing scratch or program storage.

---
 rtl/param_memory.sv | 127 ++++++++++++
 tb/tb_param_memory.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/param_memory.sv
// Parametrised single-port synchronous RAM with a registered read and a valid/ready handshake.
// Also provides per-bit write masking, a post-reset clear engine and sticky out-of-range detection.
module param_memory #(
  parameter int    DATA_W         = 8,
  parameter int    ADDR_W         = 8,
  parameter int    DEPTH          = 256,
  parameter string INIT_FILE      = "",
  parameter bit    CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W-1:0] req_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              err
);

  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_L = ADDR_W'(DEPTH - 1);
  localparam logic [0:0]      ST_CLEAR = 1'b0;
  localparam logic [0:0]      ST_RUN   = 1'b1;
  localparam logic [0:0]      ST_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              err_q, err_d;

  logic              in_range_s;
  logic              accept_s;
  logic              mem_we_s;
  logic [IDX_W-1:0]  mem_idx_s;
  logic [DATA_W-1:0] mem_wdata_s;
  logic [DATA_W-1:0] rd_word_s;

  // Handshake, address decode and the single memory write port (clear engine or masked write).
  always_comb begin
    in_range_s = ({1'b0, req_addr} < DEPTH_L);
    // rst_n gates ready so nothing is accepted while reset is held, even when no clear runs.
    req_ready  = rst_n && (state_q == ST_RUN) && (!rsp_valid_q || rsp_ready);
    accept_s   = req_valid && req_ready;
    rd_word_s  = in_range_s ? mem_q[req_addr[IDX_W-1:0]] : {DATA_W{1'b0}};
    if (state_q == ST_CLEAR) begin
      mem_idx_s   = cnt_q[IDX_W-1:0];
      mem_we_s    = rst_n;
      mem_wdata_s = {DATA_W{1'b0}};
    end else begin
      mem_idx_s   = req_addr[IDX_W-1:0];
      mem_we_s    = accept_s && req_write && in_range_s;
      mem_wdata_s = (mem_q[req_addr[IDX_W-1:0]] & ~req_wmask) | (req_wdata & req_wmask);
    end
  end

  // Clear-engine sequencing: walk every word once, then hand over to normal operation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        if (cnt_q == LAST_L) begin
          state_d = ST_RUN;
          cnt_d   = {ADDR_W{1'b0}};
        end else begin
          state_d = ST_CLEAR;
          cnt_d   = cnt_q + ADDR_W'(1'b1);
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // Response slot and sticky error; a new read may replace a response consumed on the same edge.
  always_comb begin
    rsp_rdata_d = rsp_rdata_q;
    err_d       = err_q | (accept_s && !in_range_s);
    if (accept_s && !req_write) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = rd_word_s;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RESET;
      cnt_q       <= {ADDR_W{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {DATA_W{1'b0}};
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      err_q       <= err_d;
    end
  end

  // Storage array; deliberately not reset so contents survive reset when no clear is run.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_idx_s] <= mem_wdata_s;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = (state_q == ST_CLEAR);
  assign err       = err_q;

endmodule

// File: tb/tb_param_memory.sv
// Self-checking bench: three param_memory configurations driven by identical directed stimulus,
// each compared every cycle against an array-based behavioural model, plus hand-computed literals.
module tb_param_memory;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_write, rsp_ready;
  logic [7:0] req_addr, req_wdata, req_wmask;
  logic [2:0] req_ready_s, rsp_valid_s, busy_s, err_s;
  logic [7:0] rsp_rdata_s [3];

  always #5 clk = ~clk;

  param_memory #(.DATA_W(8), .ADDR_W(8), .DEPTH(16), .INIT_FILE(""), .CLEAR_ON_RESET(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_s[0]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid_s[0]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_s[0]),
    .busy(busy_s[0]), .err(err_s[0]));

  param_memory #(.DATA_W(8), .ADDR_W(5), .DEPTH(20), .INIT_FILE(""), .CLEAR_ON_RESET(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_s[1]),
    .req_write(req_write), .req_addr(req_addr[4:0]), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid_s[1]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_s[1]),
    .busy(busy_s[1]), .err(err_s[1]));

  param_memory #(.DATA_W(8), .ADDR_W(8), .DEPTH(16), .INIT_FILE(""), .CLEAR_ON_RESET(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_s[2]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid_s[2]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_s[2]),
    .busy(busy_s[2]), .err(err_s[2]));

  int         dep [3] = '{16, 20, 16};
  bit         clr [3] = '{1'b1, 1'b1, 1'b0};
  logic [7:0] m_mem   [3][256];
  bit         m_known [3][256];
  bit         m_vld [3];
  logic [7:0] m_dat [3];
  bit         m_dk  [3];
  bit         m_err [3];
  int         m_bcnt [3];
  int         checks   = 0;
  int         failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_vld[k]  = 1'b0;
      m_dat[k]  = 8'h00;
      m_dk[k]   = 1'b1;
      m_err[k]  = 1'b0;
      m_bcnt[k] = clr[k] ? dep[k] : 0;
    end
  endtask

  task automatic compare();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("req_ready[%0d]", k), {31'd0, req_ready_s[k]},
          {31'd0, rst_n && (m_bcnt[k] == 0) && (!m_vld[k] || rsp_ready)});
      chk($sformatf("rsp_valid[%0d]", k), {31'd0, rsp_valid_s[k]}, {31'd0, m_vld[k]});
      chk($sformatf("busy[%0d]", k), {31'd0, busy_s[k]}, {31'd0, m_bcnt[k] != 0});
      chk($sformatf("err[%0d]", k), {31'd0, err_s[k]}, {31'd0, m_err[k]});
      if (m_dk[k]) chk($sformatf("rsp_rdata[%0d]", k), {24'd0, rsp_rdata_s[k]}, {24'd0, m_dat[k]});
    end
  endtask

  // Applies what one rising edge must do, from the pre-edge model state and inputs.
  task automatic model_edge(input bit v, input bit w, input logic [7:0] a, input logic [7:0] d,
                            input logic [7:0] m, input bit rr);
    for (int k = 0; k < 3; k++) begin
      int ak;
      bit acc;
      ak = (k == 1) ? int'(a & 8'd31) : int'(a);
      if (m_bcnt[k] > 0) begin
        m_mem[k][dep[k] - m_bcnt[k]]   = 8'h00;
        m_known[k][dep[k] - m_bcnt[k]] = 1'b1;
        m_bcnt[k]--;
      end else begin
        acc = v && (!m_vld[k] || rr);
        if (acc && ak >= dep[k]) m_err[k] = 1'b1;
        if (acc && w && ak < dep[k]) begin
          m_mem[k][ak]   = (m_mem[k][ak] & ~m) | (d & m);
          m_known[k][ak] = m_known[k][ak] | (m == 8'hFF);
        end
        if (acc && !w) begin
          m_vld[k] = 1'b1;
          m_dat[k] = (ak < dep[k]) ? m_mem[k][ak] : 8'h00;
          m_dk[k]  = (ak < dep[k]) ? m_known[k][ak] : 1'b1;
        end else if (m_vld[k] && rr) begin
          m_vld[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic cyc(input bit v, input bit w, input logic [7:0] a, input logic [7:0] d,
                     input logic [7:0] m, input bit rr);
    req_valid = v; req_write = w; req_addr = a; req_wdata = d; req_wmask = m; rsp_ready = rr;
    #1;
    compare();
    @(posedge clk);
    if (rst_n) model_edge(v, w, a, d, m, rr);
    #1;
  endtask

  task automatic idle();                                  cyc(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1); endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] d, input logic [7:0] m); cyc(1'b1, 1'b1, a, d, m, 1'b1); endtask
  task automatic rd(input logic [7:0] a, input bit rr);  cyc(1'b1, 1'b0, a, 8'h00, 8'h00, rr); endtask
  task automatic do_reset(); rst_n = 1'b0; model_reset(); endtask

  initial begin
    int n [3];
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 256; i++) begin
        m_mem[k][i]   = 8'h00;
        m_known[k][i] = 1'b0;
      end
    req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00;
    req_wdata = 8'h00; req_wmask = 8'h00; rsp_ready = 1'b1;
    do_reset();
    repeat (2) @(posedge clk);
    #1;
    repeat (3) idle();

    // Start a clear, interrupt it at cycle 7, then time the full restart.
    rst_n = 1'b1;
    repeat (7) idle();
    do_reset();
    repeat (2) idle();
    rst_n = 1'b1;
    n = '{0, 0, 0};
    for (int i = 0; i < 24; i++) begin
      for (int k = 0; k < 3; k++) if (busy_s[k]) n[k]++;
      idle();
    end
    chk("busy_len_a", n[0], 16);
    chk("busy_len_b", n[1], 20);
    chk("busy_len_c", n[2], 0);

    for (int a = 0; a < 16; a++) rd(8'(a), 1'b1);
    chk("rd_all_last_a", {24'd0, rsp_rdata_s[0]}, 32'h00);
    chk("rd_all_valid_a", {31'd0, rsp_valid_s[0]}, 32'd1);
    idle();

    wr(8'd3, 8'hA5, 8'hFF);
    wr(8'd3, 8'h0F, 8'h0F);
    rd(8'd3, 1'b1);
    chk("mask_a", {24'd0, rsp_rdata_s[0]}, 32'hAF);
    chk("mask_b", {24'd0, rsp_rdata_s[1]}, 32'hAF);
    chk("mask_mdl", {24'd0, m_dat[0]}, 32'hAF);
    idle();

    wr(8'd1, 8'h11, 8'hFF);
    wr(8'd2, 8'h22, 8'hFF);
    wr(8'd3, 8'h33, 8'hFF);
    rd(8'd1, 1'b1);
    chk("b2b_1", {24'd0, rsp_rdata_s[0]}, 32'h11);
    rd(8'd2, 1'b1);
    chk("b2b_2", {24'd0, rsp_rdata_s[0]}, 32'h22);
    rd(8'd3, 1'b1);
    chk("b2b_3", {24'd0, rsp_rdata_s[0]}, 32'h33);
    chk("b2b_valid", {31'd0, rsp_valid_s[0]}, 32'd1);
    idle();

    rd(8'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      rd(8'd2, 1'b0);
      chk("stall_hold", {24'd0, rsp_rdata_s[0]}, 32'h11);
      chk("stall_ready", {31'd0, req_ready_s[0]}, 32'd0);
    end
    rd(8'd2, 1'b1);
    chk("stall_next", {24'd0, rsp_rdata_s[0]}, 32'h22);
    idle();

    wr(8'd25, 8'hFF, 8'hFF);
    chk("oor_err_w_b", {31'd0, err_s[1]}, 32'd1);
    rd(8'd25, 1'b1);
    chk("oor_rd_b", {24'd0, rsp_rdata_s[1]}, 32'h00);
    chk("oor_rd_a", {24'd0, rsp_rdata_s[0]}, 32'h00);
    idle();
    rd(8'd5, 1'b1);
    chk("oor_side_b", {24'd0, rsp_rdata_s[1]}, 32'h00);
    idle();
    chk("oor_sticky_b", {31'd0, err_s[1]}, 32'd1);

    // Image written before reset must survive it when no clear runs.
    wr(8'd0, 8'h01, 8'hFF);
    wr(8'd1, 8'h80, 8'hFF);
    idle();
    do_reset();
    repeat (2) idle();
    rst_n = 1'b1;
    rd(8'd0, 1'b1);
    chk("keep0_c", {24'd0, rsp_rdata_s[2]}, 32'h01);
    chk("keep0_vld_c", {31'd0, rsp_valid_s[2]}, 32'd1);
    rd(8'd1, 1'b1);
    chk("keep1_c", {24'd0, rsp_rdata_s[2]}, 32'h80);
    chk("keep_busy_c", {31'd0, busy_s[2]}, 32'd0);
    chk("err_clr_a", {31'd0, err_s[0]}, 32'd0);
    repeat (22) idle();
    rd(8'd0, 1'b1);
    chk("cleared0_a", {24'd0, rsp_rdata_s[0]}, 32'h00);
    chk("persist0_c", {24'd0, rsp_rdata_s[2]}, 32'h01);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
